// File: rtl/csr_pkg.sv
// Shared definitions for the performance-counter CSR unit:
// CSR addresses, Zicsr funct3 encodings and FSM states.
package csr_pkg;

  localparam logic [11:0] CSR_CYCLE         = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
  localparam logic [11:0] CSR_INSTRET       = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH      = 12'hC82;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;

  typedef enum logic [2:0] {
    OP_RW  = 3'b001,
    OP_RS  = 3'b010,
    OP_RC  = 3'b011,
    OP_RWI = 3'b101,
    OP_RSI = 3'b110,
    OP_RCI = 3'b111
  } csr_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } csr_state_e;

endpackage

// File: rtl/csr_counter64.sv
// One wide counter with per-half writes that win over the increment.
// Ports: clk, reset (async low), inc, inhibit, wr_lo, wr_hi, wdata, value.
module csr_counter64 #(
  parameter int CNT_W = 64,
  parameter int XLEN  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             inhibit,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic [XLEN-1:0]  wdata,
  output logic [CNT_W-1:0] value
);

  logic [CNT_W-1:0] cnt;

  // A half write leaves the other half alone and drops
  // this cycle's increment (no carry into the other half).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (wr_lo) begin
      cnt[XLEN-1:0] <= wdata;
    end else if (wr_hi) begin
      cnt[CNT_W-1:XLEN] <= wdata;
    end else if (inc && !inhibit) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign value = cnt;

endmodule

// File: rtl/csr_counter_unit.sv
// Cycle/instret counters with Zicsr access and a valid/ready response.
// Ports: req_* from EXE, retire from WB, rsp_* to WB; option CSR_MCOUNTINHIBIT_EN.
module csr_counter_unit
  import csr_pkg::*;
#(
  parameter int CNT_W    = 64,
  parameter int XLEN     = 32,
  parameter int CYC_SKIP = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [11:0]     req_addr,
  input  logic [XLEN-1:0] req_src,
  input  logic            req_src_zero,
  input  logic            retire,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_illegal
);

  csr_state_e       state, state_nxt;
  csr_op_e          op;
  logic [CNT_W-1:0] mcycle, minstret;
  logic [XLEN-1:0]  old, wval, inh_view;
  logic             sel_cy, sel_ir, sel_inh;
  logic             sel_hi, ro, known;
  logic             op_ok, wr_intent, bad;
  logic             accept, do_wr;
  logic             cy_inh, ir_inh, ir_inc;

  assign op = csr_op_e'(req_funct3);

  always_comb begin
    sel_cy  = 1'b0;
    sel_ir  = 1'b0;
    sel_inh = 1'b0;
    sel_hi  = 1'b0;
    ro      = 1'b0;
    case (req_addr)
      CSR_CYCLE:     begin sel_cy = 1'b1; ro = 1'b1; end
      CSR_CYCLEH:    begin
        sel_cy = 1'b1; sel_hi = 1'b1; ro = 1'b1;
      end
      CSR_INSTRET:   begin sel_ir = 1'b1; ro = 1'b1; end
      CSR_INSTRETH:  begin
        sel_ir = 1'b1; sel_hi = 1'b1; ro = 1'b1;
      end
      CSR_MCYCLE:    sel_cy = 1'b1;
      CSR_MCYCLEH:   begin sel_cy = 1'b1; sel_hi = 1'b1; end
      CSR_MINSTRET:  sel_ir = 1'b1;
      CSR_MINSTRETH: begin sel_ir = 1'b1; sel_hi = 1'b1; end
`ifdef CSR_MCOUNTINHIBIT_EN
      CSR_MCOUNTINHIBIT: sel_inh = 1'b1;
`endif
      default: ;
    endcase
  end

  assign known = sel_cy | sel_ir | sel_inh;

  always_comb begin
    old = '0;
    unique case (1'b1)
      sel_cy:  old = sel_hi ? mcycle[CNT_W-1:XLEN]
                            : mcycle[XLEN-1:0];
      sel_ir:  old = sel_hi ? minstret[CNT_W-1:XLEN]
                            : minstret[XLEN-1:0];
      sel_inh: old = inh_view;
      default: ;
    endcase
  end

  // Set/clear forms only write when rs1/zimm is non-zero.
  always_comb begin
    op_ok     = 1'b1;
    wr_intent = !req_src_zero;
    wval      = old | req_src;
    case (op)
      OP_RW, OP_RWI: begin
        wr_intent = 1'b1;
        wval      = req_src;
      end
      OP_RS, OP_RSI: ;
      OP_RC, OP_RCI: wval = old & ~req_src;
      default: begin
        op_ok     = 1'b0;
        wr_intent = 1'b0;
      end
    endcase
  end

  assign bad   = !known || !op_ok || (ro && wr_intent);
  assign do_wr = accept && !bad && wr_intent;

`ifdef CSR_MCOUNTINHIBIT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cy_inh <= 1'b0;
      ir_inh <= 1'b0;
    end else if (do_wr && sel_inh) begin
      cy_inh <= wval[0];
      ir_inh <= wval[2];
    end
  end
  assign inh_view = {{(XLEN-3){1'b0}}, ir_inh, 1'b0, cy_inh};
`else
  assign cy_inh   = 1'b0;
  assign ir_inh   = 1'b0;
  assign inh_view = '0;
`endif

  assign ir_inc = retire && (mcycle >= CNT_W'(CYC_SKIP));

  csr_counter64 #(.CNT_W(CNT_W), .XLEN(XLEN)) u_cycle (
    .clk     (clk),
    .reset   (reset),
    .inc     (1'b1),
    .inhibit (cy_inh),
    .wr_lo   (do_wr && sel_cy && !sel_hi),
    .wr_hi   (do_wr && sel_cy && sel_hi),
    .wdata   (wval),
    .value   (mcycle)
  );

  csr_counter64 #(.CNT_W(CNT_W), .XLEN(XLEN)) u_instret (
    .clk     (clk),
    .reset   (reset),
    .inc     (ir_inc),
    .inhibit (ir_inh),
    .wr_lo   (do_wr && sel_ir && !sel_hi),
    .wr_hi   (do_wr && sel_ir && sel_hi),
    .wdata   (wval),
    .value   (minstret)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_rdata   <= '0;
      rsp_illegal <= 1'b0;
    end else if (accept) begin
      rsp_rdata   <= bad ? '0 : old;
      rsp_illegal <= bad;
    end
  end

endmodule

// File: tb/tb_csr_counter_unit.sv
// Directed bench for csr_counter_unit: table of CSR accesses
// plus hand sequences for carry, stall, priority and reset.
module tb_csr_counter_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_funct3 = 3'b0;
  logic [11:0] req_addr = 12'h0;
  logic [31:0] req_src = 32'h0;
  logic        req_src_zero = 1'b0;
  logic        retire = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_illegal;

`ifdef CSR_MCOUNTINHIBIT_EN
  localparam logic INH_EN = 1'b1;
`else
  localparam logic INH_EN = 1'b0;
`endif

  csr_counter_unit dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_src      (req_src),
    .req_src_zero (req_src_zero),
    .retire       (retire),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_illegal  (rsp_illegal)
  );

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Called #1 after a rising edge with the unit idle.
  task automatic csr(input logic [2:0] f3, input logic [11:0] a,
                     input logic [31:0] s, input logic z,
                     input logic ret, output logic [31:0] rd,
                     output logic il, output int snap);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_funct3   = f3;
    req_addr     = a;
    req_src      = s;
    req_src_zero = z;
    retire       = ret;
    snap         = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
    retire    = 1'b0;
    chk("rsp_valid_lat", 32'(rsp_valid), 32'd1);
    rd = rsp_rdata;
    il = rsp_illegal;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [11:0] a;
    logic [31:0] s;
    logic        z;
    logic [31:0] rd;
    logic        il;
  } vec_t;

  vec_t        tbl[16];
  logic [31:0] rd;
  logic        il;
  int          sn, sw, si;
  logic [31:0] v;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{3'b001, 12'hB02, 32'h12345678, 1'b0, 32'h0, 1'b0};
    tbl[1]  = '{3'b010, 12'hB02, 32'h00000F00, 1'b0, 32'h12345678, 1'b0};
    tbl[2]  = '{3'b011, 12'hB02, 32'h000000F8, 1'b0, 32'h12345F78, 1'b0};
    tbl[3]  = '{3'b110, 12'hB82, 32'h5, 1'b0, 32'h0, 1'b0};
    tbl[4]  = '{3'b111, 12'hB82, 32'h1, 1'b0, 32'h5, 1'b0};
    tbl[5]  = '{3'b010, 12'hC02, 32'h0, 1'b1, 32'h12345F00, 1'b0};
    tbl[6]  = '{3'b010, 12'hC82, 32'h0, 1'b1, 32'h4, 1'b0};
    tbl[7]  = '{3'b001, 12'hC02, 32'hDEAD, 1'b0, 32'h0, 1'b1};
    tbl[8]  = '{3'b010, 12'hC82, 32'h1, 1'b0, 32'h0, 1'b1};
    tbl[9]  = '{3'b010, 12'hC02, 32'h0, 1'b1, 32'h12345F00, 1'b0};
    tbl[10] = '{3'b001, 12'h123, 32'h55, 1'b0, 32'h0, 1'b1};
    tbl[11] = '{3'b101, 12'hB82, 32'h0, 1'b0, 32'h4, 1'b0};
    tbl[12] = '{3'b010, 12'hC82, 32'h0, 1'b1, 32'h0, 1'b0};
    tbl[13] = '{3'b010, 12'h320, 32'h0, 1'b1, 32'h0, !INH_EN};
    tbl[14] = '{3'b001, 12'hB80, 32'h7, 1'b0, 32'h0, 1'b0};
    tbl[15] = '{3'b010, 12'hC80, 32'h0, 1'b1, 32'h7, 1'b0};

    #12;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_illegal", 32'(rsp_illegal), 32'd0);
    #10 reset = 1'b1;

    // Ten idle cycles, then cycle and instret reads.
    repeat (10) @(posedge clk);
    #1;
    csr(3'b010, 12'hC00, 0, 1'b1, 1'b0, rd, il, sn);
    chk("cycle_after_10", rd, 32'd10);
    csr(3'b010, 12'hC02, 0, 1'b1, 1'b0, rd, il, sn);
    chk("instret_zero", rd, 32'd0);

    for (int i = 0; i < 16; i++) begin
      csr(tbl[i].f3, tbl[i].a, tbl[i].s, tbl[i].z, 1'b0,
          rd, il, sn);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].rd);
      chk($sformatf("vec%0d_illegal", i), 32'(il), 32'(tbl[i].il));
    end

    // Low-half wrap carries into the high half. The earlier
    // mcycleh write dropped one low-half increment.
    csr(3'b001, 12'hB00, 32'hFFFF_FFFF, 1'b0, 1'b0, rd, il, sw);
    chk("mcycle_old_lo", rd, 32'(sw - 1));
    repeat (2) @(posedge clk);
    #1;
    csr(3'b010, 12'hB80, 0, 1'b1, 1'b0, rd, il, sn);
    chk("mcycleh_carry", rd, 32'h8);
    csr(3'b010, 12'hB00, 0, 1'b1, 1'b0, rd, il, sn);
    chk("mcycle_lo_wrap", rd, 32'(sn - sw - 2));

    // Write beats the retire increment in the same cycle.
    csr(3'b001, 12'hB02, 32'hFF, 1'b0, 1'b0, rd, il, sn);
    chk("minstret_old", rd, 32'h12345F00);
    csr(3'b011, 12'hB02, 32'hF, 1'b0, 1'b1, rd, il, sn);
    chk("rc_retire_old", rd, 32'hFF);
    csr(3'b010, 12'hB02, 0, 1'b1, 1'b0, rd, il, sn);
    chk("rc_retire_new", rd, 32'hF0);
    retire = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    retire = 1'b0;
    csr(3'b010, 12'hB02, 0, 1'b1, 1'b0, rd, il, sn);
    chk("retire_5", rd, 32'hF5);

    // Back-pressure: response held, second request stalled.
    req_valid    = 1'b1;
    req_funct3   = 3'b010;
    req_addr     = 12'hB80;
    req_src      = 0;
    req_src_zero = 1'b1;
    @(posedge clk); #1;
    req_funct3   = 3'b001;
    req_addr     = 12'hB82;
    req_src      = 32'h99;
    req_src_zero = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d_valid", k), 32'(rsp_valid), 32'd1);
      chk($sformatf("stall%0d_rdata", k), rsp_rdata, 32'h8);
      chk($sformatf("stall%0d_ready", k), 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("stall_release_valid", 32'(rsp_valid), 32'd0);
    chk("stall_release_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("second_valid", 32'(rsp_valid), 32'd1);
    chk("second_old", rsp_rdata, 32'h0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    csr(3'b010, 12'hC82, 0, 1'b1, 1'b0, rd, il, sn);
    chk("second_applied", rd, 32'h99);

    // Inhibit register (illegal address without the option).
    csr(3'b001, 12'h320, 32'h4, 1'b0, 1'b0, rd, il, sn);
`ifdef CSR_MCOUNTINHIBIT_EN
    chk("inh_wr_illegal", 32'(il), 32'd0);
    chk("inh_wr_old", rd, 32'h0);
`else
    chk("inh_wr_illegal", 32'(il), 32'd1);
    chk("inh_wr_rdata", rd, 32'h0);
`endif
    csr(3'b010, 12'hB00, 0, 1'b1, 1'b0, rd, il, sn);
    chk("mcycle_pre", rd, 32'(sn - sw - 2));
    retire = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    retire = 1'b0;
    csr(3'b010, 12'hB02, 0, 1'b1, 1'b0, rd, il, sn);
    chk("minstret_inh", rd, INH_EN ? 32'hF5 : 32'hFD);
    csr(3'b010, 12'hB00, 0, 1'b1, 1'b0, rd, il, sn);
    chk("mcycle_runs", rd, 32'(sn - sw - 2));
`ifdef CSR_MCOUNTINHIBIT_EN
    csr(3'b001, 12'h320, 32'hFFFF_FFFF, 1'b0, 1'b0, rd, il, si);
    chk("inh_old4", rd, 32'h4);
    csr(3'b010, 12'h320, 0, 1'b1, 1'b0, rd, il, sn);
    chk("inh_mask", rd, 32'h5);
    v = 32'(si - sw - 1);
    csr(3'b010, 12'hB00, 0, 1'b1, 1'b0, rd, il, sn);
    chk("cy_frozen_a", rd, v);
    repeat (3) @(posedge clk);
    #1;
    csr(3'b010, 12'hB00, 0, 1'b1, 1'b0, rd, il, sn);
    chk("cy_frozen_b", rd, v);
    csr(3'b001, 12'h320, 32'h0, 1'b0, 1'b0, rd, il, sn);
    chk("inh_old5", rd, 32'h5);
`endif

    // Reset in the response cycle drops the response at once.
    req_valid    = 1'b1;
    req_funct3   = 3'b010;
    req_addr     = 12'hC00;
    req_src_zero = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_rdata", rsp_rdata, 32'd0);
    retire = 1'b1;
    #3 reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    retire = 1'b0;
    csr(3'b010, 12'hC02, 0, 1'b1, 1'b0, rd, il, sn);
    chk("instret_skip", rd, 32'd2);
    csr(3'b010, 12'hC80, 0, 1'b1, 1'b0, rd, il, sn);
    chk("cycleh_reset", rd, 32'd0);
    csr(3'b010, 12'hC00, 0, 1'b1, 1'b0, rd, il, sn);
    chk("cycle_restart", rd, 32'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
